// File: rtl/drac_pkg.sv
// Shared fetch-path types.
//   addr_t          : PC type, ADDR_SIZE bits
//   fetch_slot_t    : one fetch response buffer entry (pc, instr, xcpt, filled)
//   FETCH_BUF_DEPTH : default number of fetch response buffer slots
package drac_pkg;

    localparam int ADDR_SIZE       = 40;
    localparam int FETCH_BUF_DEPTH = 4;

    typedef logic [ADDR_SIZE-1:0] addr_t;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] instr;
        logic        xcpt;
        logic        filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_resp_buffer.sv
// In-order fetch response buffer between the icache/bootrom interface and decode.
// A slot is allocated (tagged with the PC) when a request is accepted. It is
// filled by the next in-order response and handed to decode with valid/ready.
// After a flush, responses still owed to killed requests are counted and dropped.
//
// Ports:
//   clk_i, rstn_i           clock, async active-low reset
//   req_fire_i, req_pc_i    accepted fetch request and its PC
//   can_issue_o             a free slot exists
//   resp_valid_i, resp_data_i, resp_xcpt_i   in-order response from the icache
//   flush_i                 kill everything buffered and in flight
//   out_valid_o, out_pc_o, out_instr_o, out_xcpt_o, out_ready_i   decode handshake
//   occupancy_o             allocated slots
//   stale_drop_o            one-cycle pulse after a stale response was discarded
module fetch_resp_buffer
    import drac_pkg::*;
#(
    parameter int DEPTH  = FETCH_BUF_DEPTH,
    parameter int ADDR_W = ADDR_SIZE,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_fire_i,
    input  logic [ADDR_W-1:0] req_pc_i,
    output logic              can_issue_o,
    input  logic              resp_valid_i,
    input  logic [31:0]       resp_data_i,
    input  logic              resp_xcpt_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [31:0]       out_instr_o,
    output logic              out_xcpt_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  occupancy_o,
    output logic              stale_drop_o
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DROP_MAX = {1'b0, {CNT_W{1'b1}}};

    fetch_slot_t      slots_q [DEPTH];
    fetch_slot_t      slots_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    // pend counts allocated-but-unfilled slots; fill==tail alone is ambiguous when full.
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             stale_drop_q, stale_drop_d;

    fetch_slot_t      head_slot;
    logic             stale, alloc, fill, pop;
    logic [CNT_W:0]   drop_sum;

    assign head_slot    = slots_q[head_q];
    assign out_valid_o  = head_slot.filled;
    assign out_pc_o     = ADDR_W'(head_slot.pc);
    assign out_xcpt_o   = head_slot.xcpt;
    assign out_instr_o  = head_slot.xcpt ? 32'h0 : head_slot.instr;
    assign can_issue_o  = (occ_q < DEPTH_C);
    assign occupancy_o  = occ_q;
    assign stale_drop_o = stale_drop_q;

    // A response in the flush cycle still belongs to the killed requests.
    assign stale = resp_valid_i & (flush_i | (drop_q != '0));
    // A request in the flush cycle lands in the emptied buffer, so it is always accepted.
    assign alloc = req_fire_i & (flush_i | can_issue_o);
    assign fill  = resp_valid_i & ~stale & (pend_q != '0);
    assign pop   = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        slots_d      = slots_q;
        head_d       = head_q;
        fill_d       = fill_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        pend_d       = pend_q;
        drop_d       = drop_q;
        stale_drop_d = stale;
        drop_sum     = '0;

        if (flush_i) begin
            drop_sum = {1'b0, drop_q} + {1'b0, pend_q};
            if (stale && drop_sum != '0) begin
                drop_sum = drop_sum - 1'b1;
            end
            drop_d = (drop_sum > DROP_MAX) ? DROP_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
            for (int i = 0; i < DEPTH; i++) begin
                slots_d[i].filled = 1'b0;
            end
            head_d = '0;
            fill_d = '0;
            tail_d = '0;
            occ_d  = '0;
            pend_d = '0;
            if (alloc) begin
                slots_d[0].pc = addr_t'(req_pc_i);
                tail_d        = PTR_W'(1);
                occ_d         = CNT_W'(1);
                pend_d        = CNT_W'(1);
            end
        end else begin
            if (stale) begin
                drop_d = drop_q - 1'b1;
            end
            if (alloc) begin
                slots_d[tail_q].pc     = addr_t'(req_pc_i);
                slots_d[tail_q].filled = 1'b0;
                tail_d                 = tail_q + 1'b1;
            end
            if (fill) begin
                slots_d[fill_q].instr  = resp_data_i;
                slots_d[fill_q].xcpt   = resp_xcpt_i;
                slots_d[fill_q].filled = 1'b1;
                fill_d                 = fill_q + 1'b1;
            end
            if (pop) begin
                slots_d[head_q].filled = 1'b0;
                head_d                 = head_q + 1'b1;
            end
            occ_d  = occ_q + CNT_W'(alloc) - CNT_W'(pop);
            pend_d = pend_q + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            head_q       <= '0;
            fill_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            pend_q       <= '0;
            drop_q       <= '0;
            stale_drop_q <= 1'b0;
        end else begin
            slots_q      <= slots_d;
            head_q       <= head_d;
            fill_q       <= fill_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            stale_drop_q <= stale_drop_d;
        end
    end

    // Protocol checks; the offending request or response is ignored by the logic above.
    always @(posedge clk_i) begin
        if (rstn_i) begin
            a_fire_when_full: assert (!(req_fire_i && !flush_i && occ_q == DEPTH_C));
            a_resp_no_outstanding: assert (!(resp_valid_i && !stale && pend_q == '0));
        end
    end

endmodule

// File: tb/tb_fetch_resp_buffer.sv
module tb_fetch_resp_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 40;
    localparam int CNT_W  = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              req_fire_i;
    logic [ADDR_W-1:0] req_pc_i;
    logic              can_issue_o;
    logic              resp_valid_i;
    logic [31:0]       resp_data_i;
    logic              resp_xcpt_i;
    logic              flush_i;
    logic              out_valid_o;
    logic [ADDR_W-1:0] out_pc_o;
    logic [31:0]       out_instr_o;
    logic              out_xcpt_o;
    logic              out_ready_i;
    logic [CNT_W-1:0]  occupancy_o;
    logic              stale_drop_o;

    fetch_resp_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_fire_i   (req_fire_i),
        .req_pc_i     (req_pc_i),
        .can_issue_o  (can_issue_o),
        .resp_valid_i (resp_valid_i),
        .resp_data_i  (resp_data_i),
        .resp_xcpt_i  (resp_xcpt_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_pc_o     (out_pc_o),
        .out_instr_o  (out_instr_o),
        .out_xcpt_o   (out_xcpt_o),
        .out_ready_i  (out_ready_i),
        .occupancy_o  (occupancy_o),
        .stale_drop_o (stale_drop_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
        logic              xcpt;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] pend_q[$];
    int                m_drop = 0;
    int                m_occ  = 0;
    int                checks = 0;
    int                failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_can_issue"}, 64'(can_issue_o), 64'd1);
        chk({tag, "_stale"},     64'(stale_drop_o), 64'd0);
        chk({tag, "_occ"},       64'(occupancy_o), 64'd0);
        chk({tag, "_pc"},        64'(out_pc_o), 64'd0);
        chk({tag, "_instr"},     64'(out_instr_o), 64'd0);
        chk({tag, "_xcpt"},      64'(out_xcpt_o), 64'd0);
    endtask

    // One clock cycle: drive inputs, update the model, check handshake before the edge
    // and registered state after it.
    task automatic cycle(input logic fire, input logic [ADDR_W-1:0] pc,
                         input logic resp, input logic [31:0] data, input logic xcpt,
                         input logic flush, input logic ready);
        exp_t e;
        logic hs;
        logic exp_stale;
        req_fire_i   = fire;
        req_pc_i     = pc;
        resp_valid_i = resp;
        resp_data_i  = data;
        resp_xcpt_i  = xcpt;
        flush_i      = flush;
        out_ready_i  = ready;

        chk("can_issue_pre", 64'(can_issue_o), 64'(m_occ < DEPTH));
        hs = (exp_q.size() != 0) && ready && !flush;
        if (hs) begin
            e = exp_q.pop_front();
            chk("out_pc",    64'(out_pc_o), 64'(e.pc));
            chk("out_instr", 64'(out_instr_o), 64'(e.instr));
            chk("out_xcpt",  64'(out_xcpt_o), 64'(e.xcpt));
        end

        exp_stale = resp && (flush || m_drop > 0);
        if (flush) begin
            m_drop = m_drop + pend_q.size();
            if (resp && m_drop > 0) m_drop--;
            pend_q.delete();
            exp_q.delete();
            m_occ = 0;
        end else begin
            if (resp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    e.pc    = pend_q.pop_front();
                    e.instr = xcpt ? 32'h0 : data;
                    e.xcpt  = xcpt;
                    exp_q.push_back(e);
                end
            end
            if (hs) m_occ--;
        end
        if (fire) begin
            pend_q.push_back(pc);
            m_occ++;
        end

        @(posedge clk_i);
        #1;
        chk("stale_drop", 64'(stale_drop_o), 64'(exp_stale));
        chk("occupancy",  64'(occupancy_o), 64'(m_occ));
        chk("can_issue",  64'(can_issue_o), 64'(m_occ < DEPTH));
        chk("out_valid",  64'(out_valid_o), 64'(exp_q.size() != 0));
    endtask

    task automatic fire_req(input logic [ADDR_W-1:0] pc, input logic ready);
        cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, ready);
    endtask

    task automatic respond(input logic [31:0] data, input logic xcpt, input logic ready);
        cycle(1'b0, '0, 1'b1, data, xcpt, 1'b0, ready);
    endtask

    task automatic idle(input logic ready);
        cycle(1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0, ready);
    endtask

    initial begin
        rstn_i       = 1'b0;
        req_fire_i   = 1'b0;
        req_pc_i     = '0;
        resp_valid_i = 1'b0;
        resp_data_i  = '0;
        resp_xcpt_i  = 1'b0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b0;
        #3;
        chk_reset_outputs("reset");
        #9 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_reset_outputs("post_reset");

        // single fetch
        fire_req(40'h1000, 1'b1);
        respond(32'h0000_0013, 1'b0, 1'b1);
        idle(1'b1);

        // fill to full (pointers start at slot 1, so this wraps)
        fire_req(40'h0, 1'b0);
        fire_req(40'h4, 1'b0);
        fire_req(40'h8, 1'b0);
        fire_req(40'hC, 1'b0);
        respond(32'hA000_0000, 1'b0, 1'b0);
        respond(32'hA000_0004, 1'b0, 1'b0);
        respond(32'hA000_0008, 1'b0, 1'b0);
        respond(32'hA000_000C, 1'b0, 1'b0);
        // pop at full: can_issue_o stays 0 this cycle, 1 after
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // alloc, fill and pop together
        fire_req(40'h5000, 1'b0);
        fire_req(40'h5004, 1'b0);
        fire_req(40'h5008, 1'b0);
        respond(32'hB000_5000, 1'b0, 1'b0);
        cycle(1'b1, 40'h500C, 1'b1, 32'hB000_5004, 1'b0, 1'b0, 1'b1);
        respond(32'hB000_5008, 1'b0, 1'b1);
        respond(32'hB000_500C, 1'b0, 1'b1);
        idle(1'b1);

        // flush with three in flight
        fire_req(40'h6000, 1'b1);
        fire_req(40'h6004, 1'b1);
        fire_req(40'h6008, 1'b1);
        cycle(1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        respond(32'hBAD0_0000, 1'b0, 1'b1);
        respond(32'hBAD0_0001, 1'b0, 1'b1);
        respond(32'hBAD0_0002, 1'b0, 1'b1);
        fire_req(40'h2000, 1'b1);
        respond(32'h0000_DEAD, 1'b0, 1'b1);
        idle(1'b1);

        // flush, stale response and new request in the same cycle
        fire_req(40'h3100, 1'b0);
        fire_req(40'h3104, 1'b0);
        cycle(1'b1, 40'h3000, 1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 1'b0);
        respond(32'hBAD0_0004, 1'b0, 1'b0);
        respond(32'h0000_3000, 1'b0, 1'b1);
        idle(1'b1);

        // page fault
        fire_req(40'h4000, 1'b0);
        respond(32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("pf_xcpt",  64'(out_xcpt_o), 64'd1);
        chk("pf_instr", 64'(out_instr_o), 64'd0);
        chk("pf_pc",    64'(out_pc_o), 64'h4000);
        idle(1'b1);

        // async reset mid-stream
        fire_req(40'h7000, 1'b0);
        fire_req(40'h7004, 1'b0);
        respond(32'h0000_7000, 1'b0, 1'b0);
        req_fire_i   = 1'b0;
        resp_valid_i = 1'b0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        exp_q.delete();
        pend_q.delete();
        m_drop = 0;
        m_occ  = 0;
        #2 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        fire_req(40'h8000, 1'b0);
        respond(32'h0000_8000, 1'b0, 1'b1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
